// File: rtl/storm_pio_loader.sv
`default_nettype none
// ============================================================================
// Module      : storm_pio_loader
// Description : Host PIO link receiver. It takes framed bytes from the host
//               over a toggle-strobe handshake and writes 16-bit words into
//               the STORM IRAM/DRAM write ports. It holds the STORM core in
//               reset until the host issues RUN.
//               Optional build macro: PIO_CHECKSUM_EN adds a trailing CSUM
//               byte to every frame (8-bit sum of all frame bytes) and refuses
//               RUN while the sticky error is set.
// Revision    : 1.0 - initial release
// ============================================================================
module storm_pio_loader #(
   parameter int ADDRI_W     = 9,
   parameter int ADDRD_W     = 10,
   parameter int SYNC_STAGES = 2
) (
   input  logic               iClk,
   input  logic               iRst,
   input  logic [1:0]         iCtrl,
   input  logic [7:0]         iPData,
   output logic               oAck,
   output logic [ADDRI_W-1:0] oIAddr,
   output logic [15:0]        oIData,
   output logic               oIWe,
   output logic [ADDRD_W-1:0] oDAddr,
   output logic [15:0]        oDData,
   output logic               oDWe,
   output logic               oCoreRst,
   output logic               oErr
);

   // One internal address register wide enough for either memory.
   localparam int AW = (ADDRI_W > ADDRD_W) ? ADDRI_W : ADDRD_W;

   typedef enum logic [3:0] {
      S_IDLE, S_CMD, S_ADH, S_ADL, S_CNH, S_CNL, S_DHI, S_DLO, S_CSUM
   } state_t;

   logic [SYNC_STAGES-1:0][1:0] sync_q;
   logic                        ack_q, bval_q;
   logic [7:0]                  byte_q;
   logic                        strobe_s, session_s;

   state_t           state_q, state_d;
   logic             tgt_q, tgt_d;           // 0 = IRAM, 1 = DRAM
   logic [7:0]       ah_q, ah_d, cnh_q, cnh_d, dh_q, dh_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [15:0]      cnt_q, cnt_d;
   logic [ADDRI_W-1:0] iaddr_q, iaddr_d;
   logic [ADDRD_W-1:0] daddr_q, daddr_d;
   logic [15:0]      idata_q, idata_d, ddata_q, ddata_d;
   logic             iwe_q, iwe_d, dwe_q, dwe_d;
   logic             core_q, core_d, err_q, err_d;
`ifdef PIO_CHECKSUM_EN
   logic [7:0]       sum_q, sum_d;
   logic             run_q, run_d;
   localparam state_t S_END = S_CSUM;
`else
   localparam state_t S_END = S_IDLE;
`endif

   assign strobe_s  = sync_q[SYNC_STAGES-1][0];
   assign session_s = sync_q[SYNC_STAGES-1][1];

   // Synchronise the async host control lines.
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], iCtrl};
   end

   // Byte handshake: capture data and echo the strobe in the same edge, so a
   // byte is seen exactly once; the FSM consumes it on the following cycle.
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         ack_q  <= 1'b0;
         bval_q <= 1'b0;
         byte_q <= 8'h00;
      end else if (strobe_s != ack_q) begin
         ack_q  <= strobe_s;
         bval_q <= 1'b1;
         byte_q <= iPData;
      end else begin
         bval_q <= 1'b0;
      end
   end

   // Frame parser: next state, write strobes and control flags.
   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      ah_d    = ah_q;
      cnh_d   = cnh_q;
      dh_d    = dh_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      iaddr_d = iaddr_q;
      daddr_d = daddr_q;
      idata_d = idata_q;
      ddata_d = ddata_q;
      iwe_d   = 1'b0;
      dwe_d   = 1'b0;
      core_d  = core_q;
      err_d   = err_q;
`ifdef PIO_CHECKSUM_EN
      sum_d   = sum_q;
      run_d   = run_q;
      if (bval_q) sum_d = sum_q + byte_q;
`endif
      if (state_q != S_IDLE && !session_s) begin
         // Session dropped: abandon the frame, any half-word is discarded.
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (session_s) state_d = S_CMD;
            S_CMD: if (bval_q) begin
`ifdef PIO_CHECKSUM_EN
               sum_d = byte_q;
               run_d = 1'b0;
`endif
               case (byte_q)
                  8'h01, 8'h02: begin
                     tgt_d   = (byte_q == 8'h02);
                     core_d  = 1'b1;
                     state_d = S_ADH;
                  end
                  8'h03: begin
`ifdef PIO_CHECKSUM_EN
                     run_d   = 1'b1;
                     state_d = S_CSUM;
`else
                     core_d  = 1'b0;
                     state_d = S_IDLE;
`endif
                  end
                  default: begin
                     err_d   = 1'b1;
                     state_d = S_IDLE;
                  end
               endcase
            end
            S_ADH: if (bval_q) begin ah_d  = byte_q; state_d = S_ADL; end
            S_ADL: if (bval_q) begin addr_d = AW'({ah_q, byte_q}); state_d = S_CNH; end
            S_CNH: if (bval_q) begin cnh_d = byte_q; state_d = S_CNL; end
            S_CNL: if (bval_q) begin
               cnt_d   = {cnh_q, byte_q};
               state_d = ({cnh_q, byte_q} == 16'h0000) ? S_END : S_DHI;
            end
            S_DHI: if (bval_q) begin dh_d = byte_q; state_d = S_DLO; end
            S_DLO: if (bval_q) begin
               if (tgt_q) begin
                  dwe_d   = 1'b1;
                  daddr_d = ADDRD_W'(addr_q);
                  ddata_d = {dh_q, byte_q};
               end else begin
                  iwe_d   = 1'b1;
                  iaddr_d = ADDRI_W'(addr_q);
                  idata_d = {dh_q, byte_q};
               end
               addr_d  = addr_q + 1'b1;
               cnt_d   = cnt_q - 16'd1;
               state_d = (cnt_q == 16'd1) ? S_END : S_DHI;
            end
`ifdef PIO_CHECKSUM_EN
            S_CSUM: if (bval_q) begin
               if (byte_q != sum_q)  err_d  = 1'b1;
               else if (run_q && !err_q) core_d = 1'b0;
               state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Parser state and output registers.
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         state_q <= S_IDLE;
         tgt_q   <= 1'b0;
         ah_q    <= 8'h00;
         cnh_q   <= 8'h00;
         dh_q    <= 8'h00;
         addr_q  <= '0;
         cnt_q   <= 16'h0000;
         iaddr_q <= '0;
         daddr_q <= '0;
         idata_q <= 16'h0000;
         ddata_q <= 16'h0000;
         iwe_q   <= 1'b0;
         dwe_q   <= 1'b0;
         core_q  <= 1'b1;
         err_q   <= 1'b0;
`ifdef PIO_CHECKSUM_EN
         sum_q   <= 8'h00;
         run_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         ah_q    <= ah_d;
         cnh_q   <= cnh_d;
         dh_q    <= dh_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         iaddr_q <= iaddr_d;
         daddr_q <= daddr_d;
         idata_q <= idata_d;
         ddata_q <= ddata_d;
         iwe_q   <= iwe_d;
         dwe_q   <= dwe_d;
         core_q  <= core_d;
         err_q   <= err_d;
`ifdef PIO_CHECKSUM_EN
         sum_q   <= sum_d;
         run_q   <= run_d;
`endif
      end
   end

   assign oAck     = ack_q;
   assign oIAddr   = iaddr_q;
   assign oIData   = idata_q;
   assign oIWe     = iwe_q;
   assign oDAddr   = daddr_q;
   assign oDData   = ddata_q;
   assign oDWe     = dwe_q;
   assign oCoreRst = core_q;
   assign oErr     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_storm_pio_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_storm_pio_loader
// Description : Self-checking bench for storm_pio_loader. Expected memory
//               writes are queued as frames are sent and compared as the
//               write enables fire.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_storm_pio_loader;

   logic        iClk = 1'b0;
   logic        iRst = 1'b0;
   logic [1:0]  iCtrl = 2'b00;
   logic [7:0]  iPData = 8'h00;
   logic        oAck, oIWe, oDWe, oCoreRst, oErr;
   logic [8:0]  oIAddr;
   logic [9:0]  oDAddr;
   logic [15:0] oIData, oDData;

   typedef struct packed {
      logic        isd;
      logic [15:0] addr;
      logic [15:0] data;
   } wr_t;

   wr_t        sb[$];
   logic [7:0] frm[$];
   int         total = 0;
   int         bad   = 0;

   storm_pio_loader dut (
      .iClk(iClk), .iRst(iRst), .iCtrl(iCtrl), .iPData(iPData), .oAck(oAck),
      .oIAddr(oIAddr), .oIData(oIData), .oIWe(oIWe),
      .oDAddr(oDAddr), .oDData(oDData), .oDWe(oDWe),
      .oCoreRst(oCoreRst), .oErr(oErr)
   );

   always #5 iClk = ~iClk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Write monitor: every enable pulse must match the head of the scoreboard.
   always @(negedge iClk) begin
      if (iRst) begin
         if (oIWe && oDWe) chk("we_both", {oIWe, oDWe}, 2'b00);
         else if (oIWe || oDWe) begin
            if (sb.size() == 0) chk("we_unexp", {oIWe, oDWe}, 2'b00);
            else begin
               wr_t e;
               e = sb.pop_front();
               chk("we_sel",  oDWe, e.isd);
               chk("we_addr", oDWe ? {6'd0, oDAddr} : {7'd0, oIAddr}, e.addr);
               chk("we_data", oDWe ? oDData : oIData, e.data);
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge iClk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge iClk);
      iPData   = b;
      iCtrl[0] = ~iCtrl[0];
      for (int i = 0; i < 40; i++) begin
         @(negedge iClk);
         if (oAck == iCtrl[0]) break;
      end
      chk("ack", oAck, iCtrl[0]);
   endtask

   // Sends frm; with add_csum the trailing sum byte is appended in checksum builds.
   task automatic send_frame(input bit add_csum);
      logic [7:0] s;
      s = 8'h00;
      foreach (frm[i]) begin
         send_byte(frm[i]);
         s = s + frm[i];
      end
`ifdef PIO_CHECKSUM_EN
      if (add_csum) send_byte(s);
`else
      if (add_csum) s = 8'h00;
`endif
      cycles(4);
   endtask

   task automatic exp_wr(input logic isd, input logic [15:0] a, input logic [15:0] d);
      wr_t e;
      e.isd = isd; e.addr = a; e.data = d;
      sb.push_back(e);
   endtask

   initial begin
      cycles(3);
      chk("rst_ack",  oAck, 1'b0);
      chk("rst_core", oCoreRst, 1'b1);
      chk("rst_err",  oErr, 1'b0);
      chk("rst_we",   {oIWe, oDWe}, 2'b00);
      chk("rst_addr", {oIAddr, oDAddr}, 19'd0);
      iRst = 1'b1;
      cycles(2);

      // 1: session off, strobe toggles are acked but do nothing.
      send_byte(8'h01);
      send_byte(8'h02);
      cycles(4);
      chk("s0_core", oCoreRst, 1'b1);
      chk("s0_err",  oErr, 1'b0);

      iCtrl[1] = 1'b1;
      cycles(5);

      // 2: IRAM write of two words.
      exp_wr(1'b0, 16'h010, 16'h1234);
      exp_wr(1'b0, 16'h011, 16'hABCD);
      frm = {8'h01, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
      send_frame(1'b1);
      chk("t2_sb", sb.size(), 0);

      // 3: DRAM write wrapping from the top address to zero.
      exp_wr(1'b1, 16'h3FF, 16'h55AA);
      exp_wr(1'b1, 16'h000, 16'h66BB);
      frm = {8'h02, 8'h03, 8'hFF, 8'h00, 8'h02, 8'h55, 8'hAA, 8'h66, 8'hBB};
      send_frame(1'b1);
      chk("t3_sb", sb.size(), 0);
      chk("t3_err", oErr, 1'b0);

      // 4: RUN releases the core, a later load frame re-holds it.
      chk("t4_pre", oCoreRst, 1'b1);
      frm = {8'h03};
      send_frame(1'b1);
      chk("t4_run", oCoreRst, 1'b0);
      frm = {8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
      send_frame(1'b1);
      chk("t4_rehold", oCoreRst, 1'b1);

      // 5: session drop mid-frame discards the half word.
      frm = {8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h12};
      foreach (frm[i]) send_byte(frm[i]);
      iCtrl[1] = 1'b0;
      cycles(6);
      send_byte(8'h34);
      cycles(4);
      chk("t5_err", oErr, 1'b0);
      iCtrl[1] = 1'b1;
      cycles(5);
      exp_wr(1'b0, 16'h020, 16'hCAFE);
      frm = {8'h01, 8'h00, 8'h20, 8'h00, 8'h01, 8'hCA, 8'hFE};
      send_frame(1'b1);
      chk("t5_sb", sb.size(), 0);
      chk("t5_err2", oErr, 1'b0);

`ifdef PIO_CHECKSUM_EN
      // 6: bad checksum still writes but sets error; RUN is then refused.
      exp_wr(1'b1, 16'h000, 16'h0001);
      frm = {8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00};
      send_frame(1'b0);
      chk("t6_sb", sb.size(), 0);
      chk("t6_err", oErr, 1'b1);
      frm = {8'h03, 8'h03};
      send_frame(1'b0);
      chk("t6_norun", oCoreRst, 1'b1);
`endif

      // Bad command sets the sticky error.
      frm = {8'h7F};
      send_frame(1'b0);
      chk("bad_cmd", oErr, 1'b1);
`ifndef PIO_CHECKSUM_EN
      frm = {8'h03};
      send_frame(1'b0);
      chk("run_err", oCoreRst, 1'b0);
`endif

      // Reset mid-frame returns everything to reset values.
      send_byte(8'h01);
      send_byte(8'h00);
      iRst = 1'b0;
      iCtrl = 2'b00;
      cycles(2);
      chk("mr_ack",  oAck, 1'b0);
      chk("mr_core", oCoreRst, 1'b1);
      chk("mr_err",  oErr, 1'b0);
      iRst = 1'b1;
      cycles(4);
      chk("mr_sb", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
